ahbl_apb_bridge: RTL and testbench
==================================

Name: ahbl_apb_bridge

Overview:
- AHB-Lite slave that converts single AHB transfers into APB3 transfers.
- Occupies one 256 MB page of the AHB address map and sits directly downstream of the AHB-Lite splitter/decoder.
- Its HREADYOUT and HRDATA feed one slave port of the splitter; the bus HREADY comes back from the splitter.
- Drives a single APB segment with one PSEL. Further APB slave decoding happens downstream.

Parameters:
- ADDR_W, 16: PADDR width; PADDR = HADDR[ADDR_W-1:0].
- TIMEOUT, 255: maximum ACCESS cycles with PREADY=0 before the bridge forces an error. 0 disables the timeout. Counter width is clog2(TIMEOUT+1), minimum 1.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select from the address decoder
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type; only bit 1 is used
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready, returned from the splitter
- HREADYOUT  out  1  bridge ready
- HRDATA  out  32  read data
- HRESP  out  1  1 = ERROR
- PADDR  out  ADDR_W  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Clock is HCLK. Reset is HRESETn, asynchronous, active-low.
- Reset values: state=IDLE; PSEL=0; PENABLE=0; PWRITE=0; PADDR=0; timeout counter=0; HREADYOUT=1; HRESP=0.
- Transfer accepted: go = HSEL & HTRANS[1] & HREADY. On go, register PADDR (from HADDR[ADDR_W-1:0]) and PWRITE (from HWRITE).
- HTRANS IDLE or BUSY, or HSEL=0, is ignored and gets a zero-wait OKAY.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - go -> SETUP.
  - HREADYOUT=1, HRESP=0.
- SETUP (one cycle):
  - PSEL=1, PENABLE=0, HREADYOUT=0, HRESP=0.
  - Always -> ACCESS. Counter cleared.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=1 & PSLVERR=0: transfer completes this cycle. HREADYOUT=1, HRESP=0, HRDATA=PRDATA. Next state is SETUP if go (back-to-back), else IDLE.
  - PREADY=1 & PSLVERR=1: HREADYOUT=0, HRESP=1 (first error cycle) -> ERR.
  - PREADY=0: HREADYOUT=0, HRESP=0, counter increments.
  - Timeout: if TIMEOUT!=0 and counter==TIMEOUT with PREADY=0, treat as PSLVERR -> ERR. PSEL/PENABLE drop on the ERR entry edge (APB transfer abandoned).
- ERR:
  - PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=1 (second error cycle).
  - Next state is SETUP if go, else IDLE.
- PSEL and PENABLE are registered, driven from next-state decode, so they change only on the HCLK edge.
- Combinational outputs:
  - PWDATA = HWDATA. The AHB master holds HWDATA stable while HREADY=0, so PWDATA is stable across SETUP and ACCESS.
  - HRDATA = PRDATA at all times; it is valid only in the completing cycle.
- HREADYOUT and HRESP are combinational from state, PREADY, PSLVERR and timeout.
- Zero-wait latency:
  - Read: address phase at T0; SETUP at T1 (HREADYOUT=0); ACCESS at T2 with HREADYOUT=1 and data returned. Data phase is 2 cycles.
  - Write has the same timing.
- Back-to-back: a second go in the completing ACCESS cycle or in the ERR cycle enters SETUP directly. No idle cycle; PSEL stays 1 and PENABLE falls to 0.
- Reset asserted mid-transfer: PSEL and PENABLE clear immediately (asynchronous). No completion is signalled. After release the FSM is in IDLE.
- HSIZE and HPROT are not used. Every transfer is a full 32-bit APB access.

Test Plan:
- Write 0xCAFEF00D to HADDR 0x6000_0104, PREADY tied to 1 -> PSEL rises T1, PENABLE rises T2, PADDR=0x0104, PWRITE=1, PWDATA=0xCAFEF00D; HREADYOUT=0 at T1 and 1 at T2; HRESP=0.
- Read at 0x6000_0010, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 -> HREADYOUT low for 4 data-phase cycles, then high with HRDATA=0x12345678; PSEL/PENABLE held throughout.
- Read with PREADY=1, PSLVERR=1 -> HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; PSEL=0 in the second cycle; FSM returns to IDLE.
- TIMEOUT=4, PREADY stuck 0 -> after 4 wait cycles the two-cycle ERROR response is issued, PSEL drops, and the next transfer completes normally.
- Back-to-back write then read with no idle cycle, zero-wait -> PSEL continuously 1, PENABLE pattern 0,1,0,1, both complete with OKAY in 4 cycles total.
- Assert HRESETn low during an ACCESS wait -> PSEL=0, PENABLE=0, HREADYOUT=1 immediately; after release, an IDLE HTRANS gets a zero-wait OKAY.

Source files
------------

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 bridge: each accepted AHB transfer becomes one APB SETUP+ACCESS pair.
// Zero-wait data phase is 2 cycles; PREADY=0 stretches it, and PSLVERR or the timeout produce a two-cycle ERROR.
module ahbl_apb_bridge #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [31:0]       HRDATA,
   output logic              HRESP,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

   state_t            r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [CNT_W-1:0]  r_cnt;

   logic w_go;
   logic w_tmo;
   logic w_done;
   logic w_err_now;
   logic w_accept;
   logic w_unused;

   assign w_go      = HSEL & HTRANS[1] & HREADY;
   assign w_tmo     = (TIMEOUT != 0) && (r_state == ACCESS) && !PREADY && (r_cnt == TMO_VAL);
   assign w_done    = (r_state == ACCESS) & PREADY & ~PSLVERR;
   assign w_err_now = (r_state == ACCESS) & ((PREADY & PSLVERR) | w_tmo);
   // A new address phase is only taken when the previous data phase is finishing.
   assign w_accept  = w_go & ((r_state == IDLE) | (r_state == ERR) | w_done);

   assign HREADYOUT = (r_state == IDLE) | (r_state == ERR) | w_done;
   assign HRESP     = (r_state == ERR) | w_err_now;
   assign HRDATA    = PRDATA;
   assign PWDATA    = HWDATA;
   assign PADDR     = r_paddr;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;

   assign w_unused  = ^{HADDR[31:ADDR_W], HTRANS[0]};

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_cnt     <= '0;
      end else begin
         if (w_accept) begin
            r_paddr  <= HADDR[ADDR_W-1:0];
            r_pwrite <= HWRITE;
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state   <= SETUP;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
               end
            end
            SETUP: begin
               r_state   <= ACCESS;
               r_psel    <= 1'b1;
               r_penable <= 1'b1;
               r_cnt     <= '0;
            end
            ACCESS: begin
               if (w_err_now) begin
                  // The APB transfer is abandoned on the way into ERR.
                  r_state   <= ERR;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
               end else if (PREADY) begin
                  r_state   <= w_accept ? SETUP : IDLE;
                  r_psel    <= w_accept;
                  r_penable <= 1'b0;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
               end
            end
            ERR: begin
               r_state   <= w_accept ? SETUP : IDLE;
               r_psel    <= w_accept;
               r_penable <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed bench for ahbl_apb_bridge with TIMEOUT=4; the splitter is modelled as HREADY=HREADYOUT.
// ctrl below is {PSEL, PENABLE, HREADYOUT, HRESP}, sampled on the falling edge.
module tb_ahbl_apb_bridge;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic [15:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int n_vec  = 0;
   int n_miss = 0;
   logic [3:0] c;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;
   assign c = {PSEL, PENABLE, HREADYOUT, HRESP};

   ahbl_apb_bridge #(.ADDR_W(16), .TIMEOUT(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
      .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic nonseq(input logic [31:0] addr, input logic wr);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
   endtask

   task automatic bus_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      bus_idle(); HADDR = 32'h0; HWDATA = 32'h0;
      PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL rst_ctrl got %b want %b", c, 4'b0010); n_miss++; end
      n_vec++; if (PADDR !== 16'h0) begin $display("FAIL rst_paddr got %h want %h", PADDR, 16'h0); n_miss++; end
      n_vec++; if (PWRITE !== 1'b0) begin $display("FAIL rst_pwrite got %b want 0", PWRITE); n_miss++; end
      #1 HRESETn = 1'b1;
      tick();
   endtask

   task automatic test_write();
      nonseq(32'h6000_0104, 1'b1); PREADY = 1'b1;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL wr_t0 ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick(); bus_idle(); HWDATA = 32'hCAFE_F00D;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL wr_t1 ctrl got %b want %b", c, 4'b1000); n_miss++; end
      n_vec++; if (PADDR !== 16'h0104) begin $display("FAIL wr_paddr got %h want %h", PADDR, 16'h0104); n_miss++; end
      n_vec++; if (PWRITE !== 1'b1) begin $display("FAIL wr_pwrite got %b want 1", PWRITE); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1110) begin $display("FAIL wr_t2 ctrl got %b want %b", c, 4'b1110); n_miss++; end
      n_vec++; if (PWDATA !== 32'hCAFE_F00D) begin $display("FAIL wr_pwdata got %h want %h", PWDATA, 32'hCAFE_F00D); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL wr_t3 ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick();
   endtask

   task automatic test_read_wait();
      nonseq(32'h6000_0010, 1'b0); PREADY = 1'b0;
      tick(); bus_idle();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL rdw_setup ctrl got %b want %b", c, 4'b1000); n_miss++; end
      n_vec++; if (PADDR !== 16'h0010) begin $display("FAIL rdw_paddr got %h want %h", PADDR, 16'h0010); n_miss++; end
      n_vec++; if (PWRITE !== 1'b0) begin $display("FAIL rdw_pwrite got %b want 0", PWRITE); n_miss++; end
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge HCLK);
         n_vec++; if (c !== 4'b1100) begin $display("FAIL rdw_wait%0d ctrl got %b want %b", i, c, 4'b1100); n_miss++; end
      end
      tick(); PREADY = 1'b1; PRDATA = 32'h1234_5678;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1110) begin $display("FAIL rdw_done ctrl got %b want %b", c, 4'b1110); n_miss++; end
      n_vec++; if (HRDATA !== 32'h1234_5678) begin $display("FAIL rdw_hrdata got %h want %h", HRDATA, 32'h1234_5678); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL rdw_idle ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick();
   endtask

   task automatic test_slverr();
      nonseq(32'h6000_0020, 1'b0); PREADY = 1'b1;
      tick(); bus_idle(); PSLVERR = 1'b1;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL err_setup ctrl got %b want %b", c, 4'b1000); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1101) begin $display("FAIL err_first ctrl got %b want %b", c, 4'b1101); n_miss++; end
      tick(); PSLVERR = 1'b0;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0011) begin $display("FAIL err_second ctrl got %b want %b", c, 4'b0011); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL err_idle ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick();
   endtask

   task automatic test_timeout();
      nonseq(32'h6000_0030, 1'b1); PREADY = 1'b0;
      tick(); bus_idle(); HWDATA = 32'h0000_0030;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL tmo_setup ctrl got %b want %b", c, 4'b1000); n_miss++; end
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge HCLK);
         n_vec++; if (c !== 4'b1100) begin $display("FAIL tmo_wait%0d ctrl got %b want %b", i, c, 4'b1100); n_miss++; end
      end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1101) begin $display("FAIL tmo_first ctrl got %b want %b", c, 4'b1101); n_miss++; end
      tick(); nonseq(32'h6000_0040, 1'b0); PREADY = 1'b1; PRDATA = 32'hA5A5_5A5A;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0011) begin $display("FAIL tmo_second ctrl got %b want %b", c, 4'b0011); n_miss++; end
      tick(); bus_idle();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL tmo_next_setup ctrl got %b want %b", c, 4'b1000); n_miss++; end
      n_vec++; if (PADDR !== 16'h0040) begin $display("FAIL tmo_next_paddr got %h want %h", PADDR, 16'h0040); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1110) begin $display("FAIL tmo_next_done ctrl got %b want %b", c, 4'b1110); n_miss++; end
      n_vec++; if (HRDATA !== 32'hA5A5_5A5A) begin $display("FAIL tmo_next_hrdata got %h want %h", HRDATA, 32'hA5A5_5A5A); n_miss++; end
      tick();
   endtask

   task automatic test_back_to_back();
      nonseq(32'h6000_0200, 1'b1); PREADY = 1'b1;
      tick(); bus_idle(); HWDATA = 32'h1111_2222;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL b2b_setup1 ctrl got %b want %b", c, 4'b1000); n_miss++; end
      tick(); nonseq(32'h6000_0300, 1'b0);
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1110) begin $display("FAIL b2b_done1 ctrl got %b want %b", c, 4'b1110); n_miss++; end
      n_vec++; if (PWDATA !== 32'h1111_2222) begin $display("FAIL b2b_pwdata got %h want %h", PWDATA, 32'h1111_2222); n_miss++; end
      n_vec++; if ({PADDR, PWRITE} !== {16'h0200, 1'b1}) begin $display("FAIL b2b_cmd1 got %h/%b want 0200/1", PADDR, PWRITE); n_miss++; end
      tick(); bus_idle(); PRDATA = 32'h0BAD_BEEF;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1000) begin $display("FAIL b2b_setup2 ctrl got %b want %b", c, 4'b1000); n_miss++; end
      n_vec++; if ({PADDR, PWRITE} !== {16'h0300, 1'b0}) begin $display("FAIL b2b_cmd2 got %h/%b want 0300/0", PADDR, PWRITE); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1110) begin $display("FAIL b2b_done2 ctrl got %b want %b", c, 4'b1110); n_miss++; end
      n_vec++; if (HRDATA !== 32'h0BAD_BEEF) begin $display("FAIL b2b_hrdata got %h want %h", HRDATA, 32'h0BAD_BEEF); n_miss++; end
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL b2b_idle ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick();
   endtask

   task automatic test_reset_mid();
      nonseq(32'h6000_0050, 1'b0); PREADY = 1'b0;
      tick(); bus_idle();
      tick();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b1100) begin $display("FAIL rmid_wait ctrl got %b want %b", c, 4'b1100); n_miss++; end
      HRESETn = 1'b0;
      #1;
      n_vec++; if (c !== 4'b0010) begin $display("FAIL rmid_async ctrl got %b want %b", c, 4'b0010); n_miss++; end
      #2 HRESETn = 1'b1;
      tick(); PREADY = 1'b1; HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h6000_0060;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL rmid_idle_trans ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick(); HTRANS = 2'b01;
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL rmid_busy_trans ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick(); bus_idle();
      @(negedge HCLK);
      n_vec++; if (c !== 4'b0010) begin $display("FAIL rmid_still_idle ctrl got %b want %b", c, 4'b0010); n_miss++; end
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
